// File: rtl/panda_pkg.sv
// Shared types and constants for the panda pipeline hazard controller.
// Holds the hazard FSM state encoding, the default counter width and the load-use predicate.
package panda_pkg;

  localparam int PANDA_CNT_W = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hazard_state_e;

  // Load in EX whose destination is read by the instruction in ID (x0 never aliases).
  function automatic logic is_load_use(
    input logic       mem_re,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic       rs1_used,
    input logic [4:0] rs2,
    input logic       rs2_used
  );
    return mem_re && (rd != 5'd0) &&
           ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/panda_perf_counter.sv
// Free-running event counter with synchronous clear and enable.
// Wraps modulo 2^CNT_W.
module panda_perf_counter
  import panda_pkg::*;
#(
  parameter int CNT_W = PANDA_CNT_W
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/panda_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, redirect flushes, memory-wait stalls
// with a timeout into a sticky error state, plus three performance counters.
module panda_hazard_ctrl
  import panda_pkg::*;
#(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = PANDA_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       if_id_rs1_addr_i,
  input  logic [4:0]       if_id_rs2_addr_i,
  input  logic             if_id_rs1_used_i,
  input  logic             if_id_rs2_used_i,
  input  logic [4:0]       id_ex_rd_addr_i,
  input  logic             id_ex_mem_re_i,
  input  logic             ex_redirect_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             id_ex_stall_o,
  output logic             ex_mem_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             mem_wb_flush_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] cnt_load_use_o,
  output logic [CNT_W-1:0] cnt_mem_wait_o,
  output logic [CNT_W-1:0] cnt_flush_o
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  hazard_state_e     r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_mem_err;

  hazard_state_e w_state;
  logic          w_err;
  logic          w_mw;
  logic          w_lu;
  logic          w_redirect_act;
  logic          w_lu_act;
  logic          w_hold_all;

  // Reset forces the combinational view to RUN so the pipeline sees sane controls.
  assign w_state = rst_i ? RUN : r_state;
  assign w_err   = (w_state == ERROR);
  assign w_mw    = (w_state != ERROR) && mem_req_i && !mem_ready_i;

  assign w_lu = is_load_use(id_ex_mem_re_i, id_ex_rd_addr_i,
                            if_id_rs1_addr_i, if_id_rs1_used_i,
                            if_id_rs2_addr_i, if_id_rs2_used_i);

  // Priority: error/memory wait > redirect > load-use.
  assign w_hold_all     = w_mw || w_err;
  assign w_redirect_act = ex_redirect_i && !w_hold_all;
  assign w_lu_act       = w_lu && !ex_redirect_i && !w_hold_all;

  assign pc_stall_o     = w_hold_all || w_lu_act;
  assign if_id_stall_o  = w_hold_all || w_lu_act;
  assign id_ex_stall_o  = w_hold_all;
  assign ex_mem_stall_o = w_hold_all;
  assign if_id_flush_o  = w_redirect_act;
  assign id_ex_flush_o  = w_redirect_act || w_lu_act;
  assign mem_wb_flush_o = w_hold_all;
  assign mem_err_o      = r_mem_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mw) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (!w_mw) begin
            r_state <= RUN;
          end else if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            r_state   <= ERROR;
            r_mem_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        ERROR: begin
          r_state <= ERROR;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  panda_perf_counter #(.CNT_W(CNT_W)) u_cnt_load_use (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (w_lu_act),
    .cnt_o (cnt_load_use_o)
  );

  panda_perf_counter #(.CNT_W(CNT_W)) u_cnt_mem_wait (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (w_mw),
    .cnt_o (cnt_mem_wait_o)
  );

  panda_perf_counter #(.CNT_W(CNT_W)) u_cnt_flush (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (w_redirect_act),
    .cnt_o (cnt_flush_o)
  );

endmodule

// File: tb/tb_panda_hazard_ctrl.sv
// Directed testbench for panda_hazard_ctrl with MEM_TIMEOUT=4 and CNT_W=4.
module tb_panda_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       rs1, rs2, rd;
  logic             rs1_used, rs2_used, mem_re, redirect, mem_req, mem_ready;
  logic             pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic             if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
  logic [CNT_W-1:0] cnt_lu, cnt_mw, cnt_fl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  panda_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .if_id_rs1_addr_i (rs1),
    .if_id_rs2_addr_i (rs2),
    .if_id_rs1_used_i (rs1_used),
    .if_id_rs2_used_i (rs2_used),
    .id_ex_rd_addr_i  (rd),
    .id_ex_mem_re_i   (mem_re),
    .ex_redirect_i    (redirect),
    .mem_req_i        (mem_req),
    .mem_ready_i      (mem_ready),
    .pc_stall_o       (pc_stall),
    .if_id_stall_o    (if_id_stall),
    .id_ex_stall_o    (id_ex_stall),
    .ex_mem_stall_o   (ex_mem_stall),
    .if_id_flush_o    (if_id_flush),
    .id_ex_flush_o    (id_ex_flush),
    .mem_wb_flush_o   (mem_wb_flush),
    .mem_err_o        (mem_err),
    .cnt_load_use_o   (cnt_lu),
    .cnt_mem_wait_o   (cnt_mw),
    .cnt_flush_o      (cnt_fl)
  );

  // Control vector packed as {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, mem_wb_flush}.
  function automatic logic [6:0] ctl();
    return {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, mem_wb_flush};
  endfunction

  task automatic set_idle();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    rs1_used = 1'b0; rs2_used = 1'b0; mem_re = 1'b0;
    redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_idle();
    rst = 1'b1;
    mem_req = 1'b1;
    #1;
    checks++;
    if (ctl() !== 7'b1111001) begin
      errors++; $display("FAIL reset_mw_ctl got %b want %b", ctl(), 7'b1111001);
    end
    @(negedge clk);
    set_idle();
    #1;
    checks++;
    if (ctl() !== 7'b0000000) begin
      errors++; $display("FAIL reset_idle_ctl got %b want %b", ctl(), 7'b0000000);
    end
    checks++;
    if ({mem_err, cnt_lu, cnt_mw, cnt_fl} !== 13'd0) begin
      errors++; $display("FAIL reset_state got err=%b lu=%0d mw=%0d fl=%0d want 0", mem_err, cnt_lu, cnt_mw, cnt_fl);
    end
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    mem_re = 1'b1; rd = 5'd5; rs2 = 5'd5; rs2_used = 1'b1; rs1 = 5'd3; rs1_used = 1'b1;
    #1;
    checks++;
    if (ctl() !== 7'b1100010) begin
      errors++; $display("FAIL load_use_ctl got %b want %b", ctl(), 7'b1100010);
    end
    next_cycle();
    set_idle();
    #1;
    checks++;
    if (ctl() !== 7'b0000000) begin
      errors++; $display("FAIL load_use_release got %b want %b", ctl(), 7'b0000000);
    end
    checks++;
    if (cnt_lu !== 4'd1) begin
      errors++; $display("FAIL load_use_cnt got %0d want 1", cnt_lu);
    end
    // rs1 match with rs1_used=0 must not stall
    mem_re = 1'b1; rd = 5'd7; rs1 = 5'd7; rs1_used = 1'b0;
    #1;
    checks++;
    if (ctl() !== 7'b0000000) begin
      errors++; $display("FAIL load_use_unused got %b want %b", ctl(), 7'b0000000);
    end
    next_cycle();
    set_idle();
  endtask

  task automatic test_x0();
    do_reset();
    mem_re = 1'b1; rd = 5'd0; rs1 = 5'd0; rs1_used = 1'b1; rs2 = 5'd0; rs2_used = 1'b1;
    #1;
    checks++;
    if (ctl() !== 7'b0000000) begin
      errors++; $display("FAIL x0_ctl got %b want %b", ctl(), 7'b0000000);
    end
    next_cycle();
    set_idle();
    #1;
    checks++;
    if (cnt_lu !== 4'd0) begin
      errors++; $display("FAIL x0_cnt got %0d want 0", cnt_lu);
    end
  endtask

  task automatic test_redirect_lu();
    do_reset();
    redirect = 1'b1; mem_re = 1'b1; rd = 5'd9; rs1 = 5'd9; rs1_used = 1'b1;
    #1;
    checks++;
    if (ctl() !== 7'b0000110) begin
      errors++; $display("FAIL redirect_lu_ctl got %b want %b", ctl(), 7'b0000110);
    end
    next_cycle();
    set_idle();
    #1;
    checks++;
    if ({cnt_fl, cnt_lu} !== {4'd1, 4'd0}) begin
      errors++; $display("FAIL redirect_lu_cnt got fl=%0d lu=%0d want fl=1 lu=0", cnt_fl, cnt_lu);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      redirect = (c == 1);
      mem_re = (c == 2); rd = 5'd4; rs1 = 5'd4; rs1_used = (c == 2);
      #1;
      checks++;
      if (ctl() !== 7'b1111001) begin
        errors++; $display("FAIL mem_wait_ctl cycle %0d got %b want %b", c, ctl(), 7'b1111001);
      end
      next_cycle();
    end
    set_idle();
    mem_req = 1'b1; mem_ready = 1'b1; redirect = 1'b1;
    #1;
    checks++;
    if (ctl() !== 7'b0000110) begin
      errors++; $display("FAIL mem_wait_release got %b want %b", ctl(), 7'b0000110);
    end
    next_cycle();
    set_idle();
    #1;
    checks++;
    if ({cnt_mw, cnt_fl, mem_err} !== {4'd3, 4'd1, 1'b0}) begin
      errors++; $display("FAIL mem_wait_cnt got mw=%0d fl=%0d err=%b want mw=3 fl=1 err=0", cnt_mw, cnt_fl, mem_err);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    // One RUN cycle enters MEM_WAIT, then 4 MEM_WAIT cycles reach the timeout.
    for (int c = 0; c < 4; c++) next_cycle();
    #1;
    checks++;
    if (mem_err !== 1'b0) begin
      errors++; $display("FAIL timeout_early got %b want 0", mem_err);
    end
    next_cycle();
    #1;
    checks++;
    if ({mem_err, cnt_mw} !== {1'b1, 4'd5}) begin
      errors++; $display("FAIL timeout_err got err=%b mw=%0d want err=1 mw=5", mem_err, cnt_mw);
    end
    set_idle();
    redirect = 1'b1; mem_re = 1'b1; rd = 5'd2; rs2 = 5'd2; rs2_used = 1'b1;
    #1;
    checks++;
    if (ctl() !== 7'b1111001) begin
      errors++; $display("FAIL error_ctl got %b want %b", ctl(), 7'b1111001);
    end
    for (int c = 0; c < 3; c++) next_cycle();
    #1;
    checks++;
    if ({mem_err, cnt_mw, cnt_fl, cnt_lu} !== {1'b1, 4'd5, 4'd0, 4'd0}) begin
      errors++; $display("FAIL error_frozen got err=%b mw=%0d fl=%0d lu=%0d want 1/5/0/0", mem_err, cnt_mw, cnt_fl, cnt_lu);
    end
    // Reset with a stale outstanding request: back in RUN it counts as a new wait.
    set_idle();
    mem_req = 1'b1;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_err, ctl()} !== {1'b0, 7'b1111001}) begin
      errors++; $display("FAIL reset_from_error got err=%b ctl=%b want err=0 ctl=1111001", mem_err, ctl());
    end
    next_cycle();
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({ctl(), cnt_mw} !== {7'b0000000, 4'd1}) begin
      errors++; $display("FAIL stale_req got ctl=%b mw=%0d want ctl=0000000 mw=1", ctl(), cnt_mw);
    end
    next_cycle();
    set_idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 17; c++) begin
      redirect = 1'b1;
      next_cycle();
    end
    set_idle();
    #1;
    checks++;
    if (cnt_fl !== 4'd1) begin
      errors++; $display("FAIL wrap_cnt got %0d want 1", cnt_fl);
    end
    mem_re = 1'b1; rd = 5'd6; rs1 = 5'd6; rs1_used = 1'b1;
    next_cycle();
    next_cycle();
    set_idle();
    #1;
    checks++;
    if (cnt_lu !== 4'd2) begin
      errors++; $display("FAIL back_to_back_lu got %0d want 2", cnt_lu);
    end
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_x0();
    test_redirect_lu();
    test_mem_wait();
    test_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/panda_hazard_ctrl.md
PANDA_HAZARD_CTRL -- requirements
Module: panda_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 256: maximum MEM_WAIT cycles before the error state.
REQ-002 Parameter CNT_W, default 32: width of the performance counters.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high. Ports are clk_i (input, 1, clock, rising edge) and rst_i (input, 1, synchronous active-high reset).
REQ-004 if_id_rs1_addr_i / if_id_rs2_addr_i, input, 5 each: source registers of the instruction in ID.
REQ-005 if_id_rs1_used_i / if_id_rs2_used_i, input, 1 each: the ID instruction reads rs1 / rs2.
REQ-006 id_ex_rd_addr_i, input, 5: destination of the instruction in EX.
REQ-007 id_ex_mem_re_i, input, 1: the EX instruction is a load.
REQ-008 ex_redirect_i, input, 1: EX resolved a taken branch or jump.
REQ-009 mem_req_i, input, 1: MEM holds a valid load or store.
REQ-010 mem_ready_i, input, 1: the data memory completes the MEM access this cycle.
REQ-011 pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o, output, 1 each: hold the register.
REQ-012 if_id_flush_o, id_ex_flush_o, mem_wb_flush_o, output, 1 each: load a bubble into the register.
REQ-013 mem_err_o, output, 1: memory timeout; sticky until reset.
REQ-014 cnt_load_use_o, cnt_mem_wait_o, cnt_flush_o, output, CNT_W each: performance counters.

Function
REQ-015 Load-use hazard (lu): id_ex_mem_re_i & id_ex_rd_addr_i!=0 & ((rs1_used & rs1==rd) | (rs2_used & rs2==rd)).
REQ-016 Memory wait (mw): mem_req_i & ~mem_ready_i, evaluated in RUN or MEM_WAIT.
REQ-017 FSM states are RUN, MEM_WAIT and ERROR; the reset state is RUN.
REQ-018 RUN -> MEM_WAIT when mw; MEM_WAIT -> RUN on the cycle mem_ready_i=1; MEM_WAIT -> ERROR when the wait counter reaches MEM_TIMEOUT-1 and mem_ready_i=0; ERROR is left only by reset.
REQ-019 The wait counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle.
REQ-020 When mw: pc/if_id/id_ex/ex_mem stalls are 1, mem_wb_flush_o=1, and every other flush is 0, including when ex_redirect_i=1.
REQ-021 While mw is active, lu and redirect are not acted on; they are re-evaluated after the stall releases.
REQ-022 In the cycle mem_ready_i=1, all outputs equal the non-wait case; there are no extra bubble cycles.
REQ-023 When ex_redirect_i & ~mw: if_id_flush_o=1, id_ex_flush_o=1, all stalls are 0, and lu is ignored.
REQ-024 When lu & ~ex_redirect_i & ~mw: pc_stall_o=1, if_id_stall_o=1, id_ex_flush_o=1, all others are 0; this is exactly one bubble, and lu clears next cycle.
REQ-025 In ERROR: all four stalls are 1, mem_wb_flush_o=1, all other flushes are 0, and mem_err_o=1.
REQ-026 All stall and flush outputs are combinational from inputs and state, with zero-cycle latency.
REQ-027 cnt_load_use_o increments each cycle the lu bubble is applied.
REQ-028 cnt_mem_wait_o increments each cycle mw is active.
REQ-029 cnt_flush_o increments each cycle a redirect flush is applied.
REQ-030 Counters wrap modulo 2^CNT_W and do not increment in ERROR.

Reset
REQ-031 On rst_i=1 at a clock edge: state=RUN, wait counter=0, mem_err_o=0, and all counters=0.
REQ-032 Reset mid-wait or in ERROR returns to RUN the next cycle; stale mem_req_i is then treated as a new access.
REQ-033 While rst_i=1, stall and flush outputs still follow REQ-020 to REQ-024 as for RUN.

Structure
REQ-034 panda_pkg holds hazard_state_e {RUN, MEM_WAIT, ERROR} and the default counter width constant.
REQ-035 One sub-module, panda_perf_counter (CNT_W, synchronous clear, enable, wrap), is instantiated three times.

Verification
REQ-036 Load-use: load x5 in EX, ID reads rs2=x5 with used=1 -> one cycle with pc_stall=1, if_id_stall=1, id_ex_flush=1; cnt_load_use=1.
REQ-037 rd=x0: load x0 in EX, ID reads x0 -> no stall or flush.
REQ-038 Redirect plus load-use in the same cycle -> if_id_flush=1 and id_ex_flush=1 with no stalls; cnt_flush=1 and cnt_load_use=0.
REQ-039 Memory wait: mem_req=1 and mem_ready held low for 3 cycles, then high -> stalls and mem_wb_flush for 3 cycles, released in cycle 4; cnt_mem_wait=3.
REQ-040 Timeout with MEM_TIMEOUT=4 and mem_ready never asserted -> ERROR after 4 wait cycles; mem_err_o=1 and frozen; reset -> RUN with mem_err_o=0.
REQ-041 Counter wrap with CNT_W=4: 17 redirects -> cnt_flush=1.
